// File: rtl/lsu_riscv.sv
// Load/store unit: turns a core load/store command into one ready-handshake memory access,
// handling byte enables, store replication, load extension, misalignment and timeouts.
module lsu_riscv #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        core_access_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic [31:0] rd_q, rd_d;
  logic        misalign_q, misalign_d;
  logic        fault_q, fault_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;

  logic        req_bad;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc;
  logic [31:0] byte_lane;
  logic [31:0] half_lane;
  logic [31:0] load_ext;
  logic        timeout_hit;

  // Request decode: legality, alignment, byte enables and replicated store data.
  always_comb begin
    req_bad = 1'b0;
    be_calc = 4'b0000;
    wd_calc = core_wd_i;
    case (core_size_i)
      3'd0, 3'd4: begin
        be_calc = 4'b0001 << core_addr_i[1:0];
        wd_calc = {4{core_wd_i[7:0]}};
      end
      3'd1, 3'd5: begin
        req_bad = core_addr_i[0];
        be_calc = 4'b0011 << {core_addr_i[1], 1'b0};
        wd_calc = {2{core_wd_i[15:0]}};
      end
      3'd2: begin
        req_bad = (core_addr_i[1:0] != 2'b00);
        be_calc = 4'b1111;
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Load lane selection uses the offset and size latched when the request was accepted.
  always_comb begin
    byte_lane = mem_rd_i >> {off_q, 3'b000};
    half_lane = mem_rd_i >> {off_q[1], 4'b0000};
    case (size_q)
      3'd0:    load_ext = {{24{byte_lane[7]}}, byte_lane[7:0]};
      3'd4:    load_ext = {24'd0, byte_lane[7:0]};
      3'd1:    load_ext = {{16{half_lane[15]}}, half_lane[15:0]};
      3'd5:    load_ext = {16'd0, half_lane[15:0]};
      default: load_ext = mem_rd_i;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (cnt_q == (32'(TIMEOUT_CYCLES) - 32'd1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_be_d   = mem_be_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    rd_d       = rd_q;
    misalign_d = misalign_q;
    fault_d    = fault_q;
    size_d     = size_q;
    off_d      = off_q;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          if (req_bad) begin
            state_d    = DONE;
            misalign_d = 1'b1;
            rd_d       = 32'd0;
          end else begin
            state_d    = BUSY;
            cnt_d      = 32'd0;
            mem_req_d  = 1'b1;
            mem_we_d   = core_we_i;
            mem_be_d   = be_calc;
            mem_addr_d = {core_addr_i[31:2], 2'b00};
            mem_wd_d   = core_we_i ? wd_calc : 32'd0;
            size_d     = core_size_i;
            off_d      = core_addr_i[1:0];
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 32'd1;
        // A completion in the same cycle as the timeout wins.
        if (mem_ready_i || timeout_hit) begin
          state_d   = DONE;
          cnt_d     = 32'd0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          fault_d   = !mem_ready_i;
          rd_d      = (mem_ready_i && !mem_we_q) ? load_ext : 32'd0;
        end
      end
      DONE: begin
        state_d    = IDLE;
        rd_d       = 32'd0;
        misalign_d = 1'b0;
        fault_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 4'b0000;
      mem_addr_q <= 32'd0;
      mem_wd_q   <= 32'd0;
      rd_q       <= 32'd0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
      size_q     <= 3'd0;
      off_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
      size_q     <= size_d;
      off_q      <= off_d;
    end
  end

  assign core_stall_o        = !rst_i && (((state_q == IDLE) && core_req_i) || (state_q == BUSY));
  assign core_rd_o           = rd_q;
  assign core_misalign_o     = misalign_q;
  assign core_access_fault_o = fault_q;
  assign mem_req_o           = mem_req_q;
  assign mem_we_o            = mem_we_q;
  assign mem_be_o            = mem_be_q;
  assign mem_addr_o          = mem_addr_q;
  assign mem_wd_o            = mem_wd_q;

endmodule

// File: tb/tb_lsu_riscv.sv
// Self-checking bench for lsu_riscv: a transaction-level model sets per-cycle expectations
// that a negedge compare process checks, plus literal checks on captured results.
module tb_lsu_riscv;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [2:0]  core_size_i = 3'd0;
  logic [31:0] core_addr_i = 32'd0;
  logic [31:0] core_wd_i = 32'd0;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_misalign_o;
  logic        core_access_fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i = 32'd0;
  logic        mem_ready_i = 1'b0;

  always #5 clk = ~clk;

  lsu_riscv #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o), .core_misalign_o(core_misalign_o),
    .core_access_fault_o(core_access_fault_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );

  int total = 0;
  int bad = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_mis, exp_flt;
  logic [3:0]  exp_be;
  logic [31:0] exp_rd, exp_addr, exp_wd;
  logic        exp_addr_chk, exp_wd_chk;

  int          stall_seen, req_seen, mis_seen, flt_seen;
  logic [31:0] last_rd, seen_addr, seen_wd;
  logic [3:0]  seen_be;
  logic        seen_we;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model in terms of access width and byte offsets.
  function automatic int nbytes(input logic [2:0] s);
    case (s)
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 1;
    endcase
  endfunction

  function automatic bit isBad(input logic [2:0] s, input logic [31:0] a);
    if (s == 3'd3 || s >= 3'd6) return 1'b1;
    return (int'(a[1:0]) % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] s, input logic [31:0] a);
    int n = nbytes(s);
    int v = ((1 << n) - 1) << int'(a[1:0]);
    return v[3:0];
  endfunction

  function automatic logic [31:0] modelWd(input logic [2:0] s, input logic [31:0] wd);
    logic [31:0] r;
    int n = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] s, input logic [31:0] a,
                                            input logic [31:0] rdata);
    int n = nbytes(s);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    logic [31:0] v = (rdata >> (8 * int'(a[1:0]))) & mask;
    if ((s == 3'd0 || s == 3'd1) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Single compare process: every cycle the bench's expectations are active.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("stall", 32'(core_stall_o), 32'(exp_stall));
      checkOutput("mem_req", 32'(mem_req_o), 32'(exp_req));
      checkOutput("mem_we", 32'(mem_we_o), 32'(exp_we));
      checkOutput("mem_be", 32'(mem_be_o), 32'(exp_be));
      checkOutput("misalign", 32'(core_misalign_o), 32'(exp_mis));
      checkOutput("fault", 32'(core_access_fault_o), 32'(exp_flt));
      checkOutput("core_rd", core_rd_o, exp_rd);
      if (exp_addr_chk) checkOutput("mem_addr", mem_addr_o, exp_addr);
      if (exp_wd_chk)   checkOutput("mem_wd", mem_wd_o, exp_wd);
      if (core_stall_o) stall_seen++;
      if (core_misalign_o) mis_seen++;
      if (core_access_fault_o) flt_seen++;
      if (mem_req_o) begin
        req_seen++;
        seen_be   = mem_be_o;
        seen_we   = mem_we_o;
        seen_addr = mem_addr_o;
        seen_wd   = mem_wd_o;
      end
    end
  end

  task automatic setIdleExp();
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_be = 4'd0;
    exp_mis = 1'b0; exp_flt = 1'b0; exp_rd = 32'd0;
    exp_addr = 32'd0; exp_wd = 32'd0; exp_addr_chk = 1'b0; exp_wd_chk = 1'b0;
  endtask

  task automatic resetSeen();
    stall_seen = 0; req_seen = 0; mis_seen = 0; flt_seen = 0;
    seen_be = 4'd0; seen_we = 1'b0; seen_addr = 32'd0; seen_wd = 32'd0;
  endtask

  task automatic idleCycles(input int n);
    core_req_i = 1'b0;
    setIdleExp();
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One full access: IDLE request cycle, BUSY cycles (ready_at<0 means never), DONE cycle.
  task automatic applyStimulus(input logic we, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rdata,
                               input int ready_at, input logic req_in_done);
    bit b = isBad(size, addr);
    bit flt = 1'b0;
    int busy_n = 0;
    core_req_i = 1'b1; core_we_i = we; core_size_i = size;
    core_addr_i = addr; core_wd_i = wd; mem_rd_i = rdata; mem_ready_i = 1'b0;
    setIdleExp();
    exp_stall = 1'b1;
    @(posedge clk); #1;
    if (!b) begin
      flt = (ready_at < 0) || (ready_at >= TO);
      busy_n = flt ? TO : ready_at + 1;
      for (int k = 0; k < busy_n; k++) begin
        mem_ready_i = (k == ready_at);
        exp_stall = 1'b1; exp_req = 1'b1; exp_we = we; exp_be = modelBe(size, addr);
        exp_addr = {addr[31:2], 2'b00}; exp_addr_chk = 1'b1;
        exp_wd = modelWd(size, wd); exp_wd_chk = we;
        @(posedge clk); #1;
      end
      mem_ready_i = 1'b0;
    end
    core_req_i = req_in_done;
    setIdleExp();
    exp_mis = b;
    exp_flt = !b && flt;
    exp_rd = (b || flt || we) ? 32'd0 : modelLoad(size, addr, rdata);
    @(negedge clk);
    last_rd = core_rd_o;
    @(posedge clk); #1;
    core_req_i = 1'b0;
    setIdleExp();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    setIdleExp();
    resetSeen();
    last_rd = 32'd0;
    core_req_i = 1'b1;
    @(negedge clk);
    checkOutput("reset_stall", 32'(core_stall_o), 32'd0);
    checkOutput("reset_req", 32'(mem_req_o), 32'd0);
    checkOutput("reset_be", 32'(mem_be_o), 32'd0);
    checkOutput("reset_addr", mem_addr_o, 32'd0);
    checkOutput("reset_rd", core_rd_o, 32'd0);
    core_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    idleCycles(2);

    resetSeen();
    applyStimulus(1'b0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0, 1'b0);
    checkOutput("lw_stall_cycles", 32'(stall_seen), 32'd2);
    checkOutput("lw_rd", last_rd, 32'hDEADBEEF);
    checkOutput("lw_be", 32'(seen_be), 32'hF);
    idleCycles(1);

    resetSeen();
    applyStimulus(1'b0, 3'd0, 32'h103, 32'd0, 32'h80123456, 1, 1'b0);
    checkOutput("lb_rd", last_rd, 32'hFFFFFF80);
    checkOutput("lb_be", 32'(seen_be), 32'h8);
    applyStimulus(1'b0, 3'd4, 32'h103, 32'd0, 32'h80123456, 0, 1'b0);
    checkOutput("lbu_rd", last_rd, 32'h00000080);

    resetSeen();
    applyStimulus(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0, 1'b0);
    checkOutput("sh_we", 32'(seen_we), 32'd1);
    checkOutput("sh_be", 32'(seen_be), 32'hC);
    checkOutput("sh_wd", seen_wd, 32'hABCDABCD);
    checkOutput("sh_addr", seen_addr, 32'h200);
    checkOutput("sh_rd", last_rd, 32'd0);

    resetSeen();
    applyStimulus(1'b0, 3'd2, 32'h101, 32'd0, 32'h11111111, 0, 1'b0);
    applyStimulus(1'b0, 3'd3, 32'h104, 32'd0, 32'h11111111, 0, 1'b0);
    applyStimulus(1'b0, 3'd5, 32'h103, 32'd0, 32'h11111111, 0, 1'b0);
    applyStimulus(1'b1, 3'd7, 32'h108, 32'h5, 32'h11111111, 0, 1'b0);
    checkOutput("misalign_no_req", 32'(req_seen), 32'd0);
    checkOutput("misalign_pulses", 32'(mis_seen), 32'd4);

    resetSeen();
    applyStimulus(1'b0, 3'd2, 32'h400, 32'd0, 32'hCAFEF00D, -1, 1'b0);
    checkOutput("timeout_req_cycles", 32'(req_seen), 32'd4);
    checkOutput("timeout_fault_pulses", 32'(flt_seen), 32'd1);
    resetSeen();
    applyStimulus(1'b0, 3'd2, 32'h404, 32'd0, 32'hCAFEF00D, 3, 1'b0);
    checkOutput("late_ready_req_cycles", 32'(req_seen), 32'd4);
    checkOutput("late_ready_no_fault", 32'(flt_seen), 32'd0);
    checkOutput("late_ready_rd", last_rd, 32'hCAFEF00D);

    applyStimulus(1'b0, 3'd1, 32'h106, 32'd0, 32'h80017FFF, 2, 1'b0);
    checkOutput("lh_rd", last_rd, 32'hFFFF8001);
    applyStimulus(1'b0, 3'd5, 32'h102, 32'd0, 32'h7FFF1234, 0, 1'b0);
    checkOutput("lhu_rd", last_rd, 32'h00007FFF);
    resetSeen();
    applyStimulus(1'b1, 3'd0, 32'h101, 32'h000000AB, 32'd0, 0, 1'b0);
    checkOutput("sb_be", 32'(seen_be), 32'h2);
    checkOutput("sb_wd", seen_wd, 32'hABABABAB);

    resetSeen();
    applyStimulus(1'b1, 3'd2, 32'h500, 32'h01020304, 32'd0, 1, 1'b1);
    applyStimulus(1'b0, 3'd2, 32'h504, 32'd0, 32'h0A0B0C0D, 0, 1'b0);
    checkOutput("b2b_req_cycles", 32'(req_seen), 32'd3);
    checkOutput("b2b_lw_rd", last_rd, 32'h0A0B0C0D);
    idleCycles(1);

    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
    core_addr_i = 32'h300; mem_ready_i = 1'b0;
    setIdleExp();
    exp_stall = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b0;
    checkOutput("pre_rst_req", 32'(mem_req_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_req", 32'(mem_req_o), 32'd0);
    checkOutput("mid_rst_stall", 32'(core_stall_o), 32'd0);
    core_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    resetSeen();
    idleCycles(2);
    checkOutput("post_rst_idle", 32'(req_seen + mis_seen + flt_seen), 32'd0);
    applyStimulus(1'b0, 3'd0, 32'h301, 32'd0, 32'h0000FE00, 0, 1'b0);
    checkOutput("post_rst_lb_rd", last_rd, 32'hFFFFFFFE);
    idleCycles(2);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
